// File: rtl/rx_bit_conditioner.sv
// Conditions the raw SWIPT comparator output into the filtered din stream and readDataIn window.
// Define RX_GLITCH_COUNT_EN to count filter disagreements during RECEIVE on glitchCount.
module rx_bit_conditioner #(
  parameter int unsigned FILTER_LEN  = 5,
  parameter int unsigned BIT_PERIOD  = 200000,
  parameter int unsigned FRAME_BITS  = 36,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned ARM_TIMEOUT = 1048575
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swiptAlive,
  input  logic [1:0] prog,
  input  logic       rxRaw,
  output logic       din,
  output logic       readDataIn,
  output logic       bitStrobe,
  output logic       frameDone,
  output logic       frameTimeout,
  output logic [7:0] glitchCount
);

  typedef enum logic [2:0] {StIdle, StArmed, StReceive, StHold, StGap} state_e;

  localparam logic [19:0] PeriodLast = 20'(BIT_PERIOD - 1);
  localparam logic [19:0] PeriodHalf = 20'(BIT_PERIOD / 2 - 1);
  localparam logic [5:0]  FrameBits  = 6'(FRAME_BITS);
  localparam logic [19:0] HoldLast   = 20'(HOLD_CYCLES - 1);
  localparam logic [19:0] ArmLast    = 20'(ARM_TIMEOUT - 1);
  localparam logic [3:0]  MajHalf    = 4'(FILTER_LEN / 2);

  state_e                state_q;
  logic                  sync_q, rx_sync_q, rx_filt_q;
  logic [FILTER_LEN-2:0] hist_q;
  logic [FILTER_LEN-1:0] window;
  logic [3:0]            ones;
  logic                  maj;
  logic                  enabled;
  logic [19:0]           period_q, arm_q, hold_q;
  logic [5:0]            bit_q;

  assign enabled = swiptAlive && (prog == 2'b11);
  // The window includes the sample being shifted in this cycle.
  assign window  = {hist_q, rx_sync_q};

  always_comb begin
    ones = '0;
    for (int i = 0; i < FILTER_LEN; i++) begin
      ones = ones + {3'b000, window[i]};
    end
    maj = (ones > MajHalf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 1'b0;
      rx_sync_q <= 1'b0;
      hist_q    <= '0;
      rx_filt_q <= 1'b0;
    end else begin
      sync_q    <= rxRaw;
      rx_sync_q <= sync_q;
      hist_q    <= window[FILTER_LEN-2:0];
      rx_filt_q <= maj;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      din          <= 1'b0;
      readDataIn   <= 1'b0;
      bitStrobe    <= 1'b0;
      frameDone    <= 1'b0;
      frameTimeout <= 1'b0;
      period_q     <= '0;
      arm_q        <= '0;
      hold_q       <= '0;
      bit_q        <= '0;
    end else begin
      bitStrobe    <= 1'b0;
      frameDone    <= 1'b0;
      frameTimeout <= 1'b0;
      if (!enabled) begin
        state_q    <= StIdle;
        din        <= 1'b0;
        readDataIn <= 1'b0;
        period_q   <= '0;
        arm_q      <= '0;
        hold_q     <= '0;
        bit_q      <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            din        <= 1'b0;
            readDataIn <= 1'b0;
            arm_q      <= '0;
            if (!rx_filt_q) begin
              state_q    <= StArmed;
              readDataIn <= 1'b1;
            end
          end
          StArmed: begin
            din        <= 1'b0;
            readDataIn <= 1'b1;
            // A start edge takes precedence over a coincident timeout.
            if (rx_filt_q) begin
              state_q  <= StReceive;
              din      <= 1'b1;
              bit_q    <= '0;
              period_q <= '0;
              arm_q    <= '0;
            end else if (arm_q == ArmLast) begin
              frameTimeout <= 1'b1;
              arm_q        <= '0;
            end else begin
              arm_q <= arm_q + 20'd1;
            end
          end
          StReceive: begin
            din        <= rx_filt_q;
            readDataIn <= 1'b1;
            if (bit_q == FrameBits && period_q == PeriodHalf) begin
              state_q   <= StHold;
              frameDone <= 1'b1;
              din       <= 1'b0;
              hold_q    <= '0;
            end else if (period_q == PeriodLast) begin
              period_q  <= '0;
              bit_q     <= bit_q + 6'd1;
              bitStrobe <= 1'b1;
            end else begin
              period_q <= period_q + 20'd1;
            end
          end
          StHold: begin
            din        <= 1'b0;
            readDataIn <= 1'b1;
            if (hold_q == HoldLast) begin
              state_q    <= StGap;
              readDataIn <= 1'b0;
            end else begin
              hold_q <= hold_q + 20'd1;
            end
          end
          StGap: begin
            din        <= 1'b0;
            readDataIn <= 1'b0;
            state_q    <= StIdle;
          end
          default: begin
            state_q    <= StIdle;
            din        <= 1'b0;
            readDataIn <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RX_GLITCH_COUNT_EN
  logic [7:0] glitch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= '0;
    end else if (enabled && state_q == StIdle && !rx_filt_q) begin
      glitch_q <= '0;
    end else if (enabled && state_q == StReceive && rx_sync_q != rx_filt_q &&
                 glitch_q != 8'hff) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitchCount = glitch_q;
`else
  assign glitchCount = 8'h00;
`endif

endmodule

// File: tb/tb_rx_bit_conditioner.sv
// Randomised self-checking bench for rx_bit_conditioner; filter and glitch expectations come
// from a queue of sampled rxRaw values evaluated with plain majority arithmetic.
module tb_rx_bit_conditioner;

  localparam int unsigned FL = 5;
  localparam int unsigned BP = 8;
  localparam int unsigned FB = 4;
  localparam int unsigned HC = 3;
  localparam int unsigned AT = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       swiptAlive = 1'b1;
  logic [1:0] prog = 2'b11;
  logic       rxRaw = 1'b0;
  logic       din, readDataIn, bitStrobe, frameDone, frameTimeout;
  logic [7:0] glitchCount;

  int errors = 0;
  int checks = 0;
  bit hist[$];

  rx_bit_conditioner #(
    .FILTER_LEN (FL),
    .BIT_PERIOD (BP),
    .FRAME_BITS (FB),
    .HOLD_CYCLES(HC),
    .ARM_TIMEOUT(AT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .swiptAlive  (swiptAlive),
    .prog        (prog),
    .rxRaw       (rxRaw),
    .din         (din),
    .readDataIn  (readDataIn),
    .bitStrobe   (bitStrobe),
    .frameDone   (frameDone),
    .frameTimeout(frameTimeout),
    .glitchCount (glitchCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Records the rxRaw value each edge samples (reset edges look like zeros).
  task automatic step();
    @(posedge clk);
    hist.push_back(rst ? 1'b0 : rxRaw);
    #1;
  endtask

  // Filtered level after edge n: majority of raw samples from edges n-FL-1 .. n-2.
  function automatic bit exp_filt(int n);
    int ones = 0;
    for (int k = n - int'(FL) - 1; k <= n - 2; k++) begin
      if (k >= 1 && hist[k-1]) ones++;
    end
    return ones > int'(FL / 2);
  endfunction

  task automatic wait_armed();
    int n = 0;
    rxRaw = 1'b0;
    while (readDataIn !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (readDataIn !== 1'b1) begin
      errors++;
      $display("FAIL wait_armed: readDataIn=%b required 1 within 20 cycles", readDataIn);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; swiptAlive = 1'b1; prog = 2'b11; rxRaw = 1'b0;
    step(); step();
    checks++;
    if ({din, readDataIn, bitStrobe, frameDone, frameTimeout, glitchCount} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0",
               {din, readDataIn, bitStrobe, frameDone, frameTimeout, glitchCount});
    end
    rst = 1'b0;
    step();
    checks++;
    if (readDataIn !== 1'b1) begin
      errors++; $display("FAIL reset_arm: readDataIn=%b required 1", readDataIn);
    end
    checks++;
    if ({din, bitStrobe, frameDone, frameTimeout, glitchCount} !== 12'd0) begin
      errors++;
      $display("FAIL reset_arm_others: got %b required 0",
               {din, bitStrobe, frameDone, frameTimeout, glitchCount});
    end
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 120; i++) begin
      step();
      checks++;
      if (frameTimeout !== 1'(i == 50 || i == 100)) begin
        errors++;
        $display("FAIL timeout_pulse cycle %0d: got %b required %b", i, frameTimeout,
                 (i == 50 || i == 100));
      end
      checks++;
      if (readDataIn !== 1'b1 || din !== 1'b0) begin
        errors++;
        $display("FAIL timeout_armed cycle %0d: readDataIn=%b din=%b required 1/0", i,
                 readDataIn, din);
      end
    end
  endtask

  task automatic test_glitch_reject();
    for (int p = 0; p < 6; p++) begin
      int len = $urandom_range(1, 2);
      int gap = $urandom_range(FL + 1, FL + 4);
      for (int c = 0; c < len + gap; c++) begin
        rxRaw = (c < len);
        step();
        checks++;
        if (din !== 1'b0 || readDataIn !== 1'b1) begin
          errors++;
          $display("FAIL glitch_reject pulse %0d: din=%b readDataIn=%b required 0/1", p, din,
                   readDataIn);
        end
      end
    end
  endtask

  task automatic test_clean_frame();
    int pre = $urandom_range(0, 3);
    repeat (pre) step();
    rxRaw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (din !== 1'(i == 6)) begin
        errors++; $display("FAIL clean_start edge %0d: din=%b required %b", i, din, (i == 6));
      end
    end
    for (int i = 1; i <= 40; i++) begin
      rxRaw = !(i == 13 || i == 14);
      step();
      checks++;
      if (bitStrobe !== 1'(i % 8 == 0 && i <= 32)) begin
        errors++; $display("FAIL clean_strobe cycle %0d: got %b", i, bitStrobe);
      end
      checks++;
      if (frameDone !== 1'(i == 36)) begin
        errors++; $display("FAIL clean_done cycle %0d: got %b", i, frameDone);
      end
      checks++;
      if (din !== 1'(i < 36)) begin
        errors++; $display("FAIL clean_din cycle %0d: got %b required %b", i, din, (i < 36));
      end
      checks++;
      if (readDataIn !== 1'(i <= 38)) begin
        errors++;
        $display("FAIL clean_window cycle %0d: got %b required %b", i, readDataIn, (i <= 38));
      end
    end
    checks++;
`ifdef RX_GLITCH_COUNT_EN
    if (glitchCount !== 8'd2) begin
      errors++; $display("FAIL clean_glitch_count: got %0d required 2", glitchCount);
    end
`else
    if (glitchCount !== 8'd0) begin
      errors++; $display("FAIL clean_glitch_count: got %0d required 0", glitchCount);
    end
`endif
    rxRaw = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      checks++;
      if (readDataIn !== 1'(j == 6)) begin
        errors++; $display("FAIL clean_rearm edge %0d: readDataIn=%b", j, readDataIn);
      end
    end
  endtask

  // Filtered start lands on the same edge the arm counter would time out.
  task automatic test_start_vs_timeout();
    for (int j = 1; j <= 51; j++) begin
      if (j == 45) rxRaw = 1'b1;
      step();
      checks++;
      if (frameTimeout !== 1'b0) begin
        errors++; $display("FAIL start_vs_timeout pulse at %0d: got %b required 0", j, frameTimeout);
      end
      if (j == 49 || j == 50) begin
        checks++;
        if (din !== 1'(j == 50)) begin
          errors++; $display("FAIL start_vs_timeout din at %0d: got %b", j, din);
        end
      end
    end
    repeat (42) step();
    wait_armed();
  endtask

  task automatic test_noisy_frame();
    int n, gl, expg;
    bit bv;
    rxRaw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (din !== 1'(i == 6)) begin
        errors++; $display("FAIL noisy_start edge %0d: din=%b", i, din);
      end
    end
    gl = 0;
    bv = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      if (i % 8 == 1) bv = 1'($urandom_range(1));
      rxRaw = bv ^ ($urandom_range(7) == 0);
      step();
      n = hist.size();
      if (hist[n-3] != exp_filt(n - 1)) gl++;
      checks++;
      if (i < 36) begin
        if (din !== exp_filt(n - 1)) begin
          errors++;
          $display("FAIL noisy_din cycle %0d: got %b required %b", i, din, exp_filt(n - 1));
        end
      end else if (din !== 1'b0 || frameDone !== 1'b1) begin
        errors++;
        $display("FAIL noisy_end: din=%b frameDone=%b required 0/1", din, frameDone);
      end
    end
`ifdef RX_GLITCH_COUNT_EN
    expg = (gl > 255) ? 255 : gl;
`else
    expg = 0;
`endif
    checks++;
    if (int'(glitchCount) != expg) begin
      errors++; $display("FAIL noisy_glitch_count: got %0d required %0d", glitchCount, expg);
    end
    rxRaw = 1'b1;
    for (int i = 37; i <= 39; i++) begin
      step();
      checks++;
      if (readDataIn !== 1'(i <= 38)) begin
        errors++; $display("FAIL noisy_window cycle %0d: got %b", i, readDataIn);
      end
    end
    repeat (2) step();
    wait_armed();
  endtask

  task automatic test_abort();
    int k = $urandom_range(16, 22);
    rxRaw = 1'b1;
    repeat (6) step();
    for (int i = 1; i <= k; i++) step();
    swiptAlive = 1'b0;
    step();
    checks++;
    if ({readDataIn, din, frameDone, bitStrobe} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_next_edge: rd/din/done/strobe=%b required 0000",
               {readDataIn, din, frameDone, bitStrobe});
    end
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (frameDone !== 1'b0 || readDataIn !== 1'b0) begin
        errors++;
        $display("FAIL abort_hold cycle %0d: frameDone=%b readDataIn=%b", i, frameDone,
                 readDataIn);
      end
    end
    swiptAlive = 1'b1;
    repeat (5) step();
    checks++;
    if (readDataIn !== 1'b0) begin
      errors++; $display("FAIL abort_no_rearm_high: readDataIn=%b required 0", readDataIn);
    end
    rxRaw = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      checks++;
      if (readDataIn !== 1'(j == 6)) begin
        errors++; $display("FAIL abort_rearm edge %0d: readDataIn=%b", j, readDataIn);
      end
    end
    for (int j = 1; j <= 50; j++) begin
      step();
      checks++;
      if (frameTimeout !== 1'(j == 50)) begin
        errors++; $display("FAIL abort_arm_cleared cycle %0d: frameTimeout=%b", j, frameTimeout);
      end
    end
  endtask

  task automatic test_disabled_program();
    prog = 2'b10;
    for (int i = 0; i < 60; i++) begin
      rxRaw = 1'($urandom_range(1));
      step();
      checks++;
      if ({readDataIn, din, bitStrobe, frameDone, frameTimeout} !== 5'b00000) begin
        errors++;
        $display("FAIL disabled_idle cycle %0d: outputs=%b required 00000", i,
                 {readDataIn, din, bitStrobe, frameDone, frameTimeout});
      end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_glitch_reject();
    test_clean_frame();
    test_start_vs_timeout();
    test_noisy_frame();
    test_abort();
    test_disabled_program();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_bit_conditioner.md
# rx_bit_conditioner

Conditions the raw SWIPT receive comparator output into the clean `din` bit stream and the `readDataIn` frame window used by the downstream frame analyser. It synchronises and majority-filters the raw input, arms a receive window, tracks frame length in bit periods, and then releases the window after a hold time. It sits between the analog comparator pin and the frame analyser.

## Interface
- `FILTER_LEN`, 5: majority-filter window in samples; odd, 3..15.
- `BIT_PERIOD`, 200000: clock cycles per bit; even, 4..2^20-2.
- `FRAME_BITS`, 36: bits per frame, 1..63.
- `HOLD_CYCLES`, 1000: cycles `readDataIn` stays high after the frame ends, ≥1.
- `ARM_TIMEOUT`, 2^20-1: cycles in ARMED without a start edge before `frameTimeout`, ≥2.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `swiptAlive` in 1: link alive; low aborts.
- `program` in 2: receive enabled only when `2'b11`.
- `rxRaw` in 1: asynchronous comparator output.
- `din` out 1: filtered bit stream to the analyser.
- `readDataIn` out 1: frame window to the analyser.
- `bitStrobe` out 1: one-cycle pulse at each bit-period boundary in RECEIVE.
- `frameDone` out 1: one-cycle pulse on entering HOLD.
- `frameTimeout` out 1: one-cycle pulse on ARMED timeout.
- `glitchCount` out 8: saturating count of filter disagreements (see Configuration).

## Operation
- Input path: `rxRaw` passes through a 2-flop synchroniser into `rxSync`. `rxSync` shifts into a FILTER_LEN window. `rxFilt` is a register loaded with the majority of the window including the sample being shifted in.
- FSM states: IDLE, ARMED, RECEIVE, HOLD, GAP. `enabled` = `swiptAlive && program==2'b11`.
- IDLE: `readDataIn`=0, `din`=0. Moves to ARMED when `enabled && rxFilt==0`.
- ARMED: `readDataIn`=1, `din`=0.
  - Arm counter increments each cycle.
  - `rxFilt==1` → RECEIVE; bit counter and period counter are cleared.
  - Arm counter ==ARM_TIMEOUT-1 → pulse `frameTimeout`, clear the counter, stay in ARMED.
  - Start edge and timeout in the same cycle: the start edge wins and there is no pulse.
- RECEIVE: `readDataIn`=1, `din` <= `rxFilt` each cycle.
  - Period counter counts 0..BIT_PERIOD-1 and wraps.
  - On wrap, the bit counter increments and `bitStrobe` pulses.
  - When bit counter==FRAME_BITS and period counter==BIT_PERIOD/2-1 → HOLD, and `frameDone` pulses.
  - RECEIVE therefore lasts exactly FRAME_BITS·BIT_PERIOD + BIT_PERIOD/2 cycles.
- HOLD: `readDataIn`=1, `din`=0 for HOLD_CYCLES cycles → GAP.
- GAP: `readDataIn`=0 for exactly one cycle → IDLE. Re-arming requires `rxFilt` low.
- Abort: `!enabled` in any state → IDLE on the next edge, and all counters clear. `frameDone` and `frameTimeout` are not pulsed.
- Counters: period counter is 20 bit, bit counter is 6 bit, arm counter is 20 bit, HOLD counter is 20 bit. None wrap except as stated.

## Timing
- Reset values: state IDLE; `din`, `readDataIn`, `bitStrobe`, `frameDone`, `frameTimeout` = 0; `glitchCount` = 0; synchroniser, window and `rxFilt` all 0.
- Filter latency: a level held stable on `rxRaw` reaches `rxFilt` on the (2+(FILTER_LEN+1)/2)-th rising edge after the first edge that samples it. This is 5 edges at FILTER_LEN=5.
- Start edge to `din`: `din` rises 1 cycle after `rxFilt` rises. This is the same edge on which the state becomes RECEIVE.
- The first `bitStrobe` occurs BIT_PERIOD cycles after entry to RECEIVE.
- `rst` has priority over abort, and abort has priority over all transitions.
- Pulses never last longer than one cycle.
- `rxRaw` pulses shorter than (FILTER_LEN+1)/2 cycles never reach `din`.

## Configuration
- `RX_GLITCH_COUNT_EN` defined:
  - `glitchCount` increments on each RECEIVE cycle where `rxSync != rxFilt`.
  - It saturates at 255.
  - It clears on `rst` and on entry to ARMED.
- `RX_GLITCH_COUNT_EN` undefined: `glitchCount` is tied to 8'h00 and no counter logic is present.

## Test plan
Test parameters: BIT_PERIOD=8, FRAME_BITS=4, FILTER_LEN=5, HOLD_CYCLES=3, ARM_TIMEOUT=50.
- Reset then enable: `rst` 1 for 2 cycles, `swiptAlive`=1, `program`=3, `rxRaw`=0 → ARMED 1 cycle after `rst` drops and `readDataIn`=1; all other outputs 0.
- Clean frame: `rxRaw` rises and is held → `din` rises 6 edges later. 4 `bitStrobe` pulses follow, spaced 8 cycles apart. `frameDone` fires 36 cycles after RECEIVE entry. `readDataIn` stays high 3 more cycles, then is low for 1 cycle, and re-arms once `rxRaw`=0.
- Glitch reject: a 2-cycle `rxRaw` pulse in ARMED → `din` stays 0 and the state stays ARMED. With RX_GLITCH_COUNT_EN, a 2-cycle dip mid-RECEIVE → `glitchCount`=2.
- Timeout: ARMED with `rxRaw`=0 for 120 cycles → `frameTimeout` pulses on cycles 50 and 100, and the state remains ARMED.
- Abort mid-frame: `swiptAlive`→0 during bit 2 → next edge `readDataIn`=0, `din`=0, state IDLE, and `frameDone` never fires.
- `program`=2'b10 with `swiptAlive`=1 → the block stays in IDLE indefinitely and `rxRaw` activity is ignored.
